// File: rtl/arch_cdc_sync_filter_if.sv
// ----------------------------------------------------------------------------
// arch_cdc_sync_filter_if
// Change-event stream carried out of arch_cdc_sync_filter.
//   chg_valid   : change event pending (producer -> consumer)
//   chg_ready   : consumer accepts the event (consumer -> producer)
//   chg_data    : filtered level vector at the most recent accepted change
//   chg_mask    : channels that changed since the last transfer
//   chg_overrun : a masked channel changed again while the event was pending
// Modports: master = producer (the synchroniser), slave = consumer.
// ----------------------------------------------------------------------------
interface arch_cdc_sync_filter_if #(
   parameter int WIDTH = 2
);
   logic             chg_valid;
   logic             chg_ready;
   logic [WIDTH-1:0] chg_data;
   logic [WIDTH-1:0] chg_mask;
   logic             chg_overrun;

   modport master (
      output chg_valid,
      output chg_data,
      output chg_mask,
      output chg_overrun,
      input  chg_ready
   );

   modport slave (
      input  chg_valid,
      input  chg_data,
      input  chg_mask,
      input  chg_overrun,
      output chg_ready
   );
endinterface

// File: rtl/arch_cdc_sync_filter.sv
// ----------------------------------------------------------------------------
// arch_cdc_sync_filter
// Multi-channel synchroniser for asynchronous level inputs. Each channel runs
// through a SYNC_STAGES flop chain and then a deglitch filter that only
// accepts a new level after FILTER_LEN consecutive cycles. Accepted changes
// produce per-channel rise/fall pulses and a coalescing change-event stream.
// Ports:
//   dst_clk   : destination clock (only clock in the block)
//   dst_rst   : synchronous active-high reset
//   async_in  : asynchronous level inputs, WIDTH channels
//   dst_data  : filtered, synchronised levels
//   dst_rise  : one-cycle pulse on an accepted 0->1 change, per channel
//   dst_fall  : one-cycle pulse on an accepted 1->0 change, per channel
//   chg       : change-event stream (master side of arch_cdc_sync_filter_if)
// ----------------------------------------------------------------------------
module arch_cdc_sync_filter #(
   parameter int               WIDTH       = 2,
   parameter int               SYNC_STAGES = 3,
   parameter int               FILTER_LEN  = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic                   dst_clk,
   input  logic                   dst_rst,
   input  logic [WIDTH-1:0]       async_in,
   output logic [WIDTH-1:0]       dst_data,
   output logic [WIDTH-1:0]       dst_rise,
   output logic [WIDTH-1:0]       dst_fall,
   arch_cdc_sync_filter_if.master chg
);
   localparam int            CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   // Stage 0 is the only flop that sees async_in; stage SYNC_STAGES-1 feeds the filter.
   (* ASYNC_REG = "TRUE", NOMERGE = "TRUE" *)
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]         data_q, data_d;
   logic [WIDTH-1:0]         rise_q, rise_d;
   logic [WIDTH-1:0]         fall_q, fall_d;

   logic                     chg_valid_q, chg_valid_d;
   logic [WIDTH-1:0]         chg_data_q, chg_data_d;
   logic [WIDTH-1:0]         chg_mask_q, chg_mask_d;
   logic                     chg_overrun_q, chg_overrun_d;

   logic [WIDTH-1:0]         chg_bits_s;   // channels of dst_data changing at this edge
   logic                     xfer_s;       // event handed to the consumer at this edge

   // Shift the synchroniser chain by one stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
   end

   // Deglitch filter: a differing level must persist FILTER_LEN cycles to be taken.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_q[SYNC_STAGES-1][i] == data_q[i]) begin
            cnt_d[i] = {CW{1'b0}};
         end else if (cnt_q[i] == CNT_MAX) begin
            data_d[i] = sync_q[SYNC_STAGES-1][i];
            cnt_d[i]  = {CW{1'b0}};
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      rise_d = data_d & ~data_q;
      fall_d = ~data_d & data_q;
   end

   // Change-event tracker: coalesces changes while an event waits for the consumer.
   always_comb begin
      chg_bits_s    = data_d ^ data_q;
      xfer_s        = chg_valid_q & chg.chg_ready;
      chg_valid_d   = chg_valid_q;
      chg_data_d    = chg_data_q;
      chg_mask_d    = chg_mask_q;
      chg_overrun_d = chg_overrun_q;
      if (!chg_valid_q) begin
         // Idle: chg_ready is ignored here.
         if (chg_bits_s != {WIDTH{1'b0}}) begin
            chg_valid_d   = 1'b1;
            chg_mask_d    = chg_bits_s;
            chg_data_d    = data_d;
            chg_overrun_d = 1'b0;
         end else begin
            chg_valid_d = 1'b0;
         end
      end else if (xfer_s) begin
         // A change landing on the transfer edge opens a fresh event so nothing is lost.
         if (chg_bits_s != {WIDTH{1'b0}}) begin
            chg_valid_d   = 1'b1;
            chg_mask_d    = chg_bits_s;
            chg_data_d    = data_d;
            chg_overrun_d = 1'b0;
         end else begin
            chg_valid_d   = 1'b0;
            chg_mask_d    = {WIDTH{1'b0}};
            chg_overrun_d = 1'b0;
         end
      end else begin
         if (chg_bits_s != {WIDTH{1'b0}}) begin
            chg_mask_d    = chg_mask_q | chg_bits_s;
            chg_data_d    = data_d;
            chg_overrun_d = chg_overrun_q | (|(chg_bits_s & chg_mask_q));
         end else begin
            chg_mask_d = chg_mask_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge dst_clk) begin
      if (dst_rst) begin
         sync_q        <= {SYNC_STAGES{RESET_VALUE}};
         cnt_q         <= {(WIDTH*CW){1'b0}};
         data_q        <= RESET_VALUE;
         rise_q        <= {WIDTH{1'b0}};
         fall_q        <= {WIDTH{1'b0}};
         chg_valid_q   <= 1'b0;
         chg_data_q    <= RESET_VALUE;
         chg_mask_q    <= {WIDTH{1'b0}};
         chg_overrun_q <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         rise_q        <= rise_d;
         fall_q        <= fall_d;
         chg_valid_q   <= chg_valid_d;
         chg_data_q    <= chg_data_d;
         chg_mask_q    <= chg_mask_d;
         chg_overrun_q <= chg_overrun_d;
      end
   end

   assign dst_data        = data_q;
   assign dst_rise        = rise_q;
   assign dst_fall        = fall_q;
   assign chg.chg_valid   = chg_valid_q;
   assign chg.chg_data    = chg_data_q;
   assign chg.chg_mask    = chg_mask_q;
   assign chg.chg_overrun = chg_overrun_q;
endmodule

// File: tb/tb_arch_cdc_sync_filter.sv
// ----------------------------------------------------------------------------
// tb_arch_cdc_sync_filter
// Directed bench for arch_cdc_sync_filter with WIDTH=4, SYNC_STAGES=3,
// FILTER_LEN=4. dut_a uses RESET_VALUE=0000, dut_b uses RESET_VALUE=1111.
// Inputs change 1 time unit after a rising edge and outputs are sampled there,
// so "step(n)" advances n rising edges.
// ----------------------------------------------------------------------------
module tb_arch_cdc_sync_filter;
   logic       clk;
   logic       rst;
   logic [3:0] async_a, async_b;
   logic [3:0] data_a, rise_a, fall_a;
   logic [3:0] data_b, rise_b, fall_b;
   logic [3:0] acc;
   logic [3:0] b_seen = 4'b0000;
   logic       mon_en;
   int         n_asserts = 0;
   int         n_fail    = 0;

   arch_cdc_sync_filter_if #(.WIDTH(4)) if_a ();
   arch_cdc_sync_filter_if #(.WIDTH(4)) if_b ();

   arch_cdc_sync_filter #(
      .WIDTH(4), .SYNC_STAGES(3), .FILTER_LEN(4), .RESET_VALUE(4'b0000)
   ) dut_a (
      .dst_clk(clk), .dst_rst(rst), .async_in(async_a),
      .dst_data(data_a), .dst_rise(rise_a), .dst_fall(fall_a), .chg(if_a)
   );

   arch_cdc_sync_filter #(
      .WIDTH(4), .SYNC_STAGES(3), .FILTER_LEN(4), .RESET_VALUE(4'b1111)
   ) dut_b (
      .dst_clk(clk), .dst_rst(rst), .async_in(async_b),
      .dst_data(data_b), .dst_rise(rise_b), .dst_fall(fall_b), .chg(if_b)
   );

   always #5 clk = ~clk;

   // Sticky record of any pulse or event from dut_b while its input is held at reset value.
   always @(negedge clk) begin
      if (mon_en) b_seen <= b_seen | rise_b | fall_b | {3'b000, if_b.chg_valid};
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_asserts++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic pulse_ready_a();
      if_a.chg_ready = 1'b1;
      step(1);
      if_a.chg_ready = 1'b0;
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; mon_en = 1'b0;
      async_a = 4'b0000; async_b = 4'b1111;
      if_a.chg_ready = 1'b0; if_b.chg_ready = 1'b0;
      step(3);
      rst = 1'b0; mon_en = 1'b1;

      // Reset state
      chk("rst_data",   data_a, 4'b0000);
      chk("rst_rise",   rise_a, 4'b0000);
      chk("rst_fall",   fall_a, 4'b0000);
      chk("rst_valid",  4'(if_a.chg_valid), 4'b0000);
      chk("rst_mask",   if_a.chg_mask, 4'b0000);
      chk("rst_cdata",  if_a.chg_data, 4'b0000);
      chk("rst_ovr",    4'(if_a.chg_overrun), 4'b0000);
      chk("rst_data_b", data_b, 4'b1111);

      // Bit0 rise: accepted exactly at edge 7
      async_a = 4'b0001;
      step(6);
      chk("lat_e6_data", data_a, 4'b0000);
      step(1);
      chk("lat_e7_data",  data_a, 4'b0001);
      chk("lat_e7_rise",  rise_a, 4'b0001);
      chk("lat_e7_fall",  fall_a, 4'b0000);
      chk("lat_e7_valid", 4'(if_a.chg_valid), 4'b0001);
      chk("lat_e7_mask",  if_a.chg_mask, 4'b0001);
      chk("lat_e7_cdata", if_a.chg_data, 4'b0001);
      chk("lat_e7_ovr",   4'(if_a.chg_overrun), 4'b0000);
      step(1);
      chk("lat_e8_rise",  rise_a, 4'b0000);
      chk("lat_e8_valid", 4'(if_a.chg_valid), 4'b0001);
      pulse_ready_a();
      chk("xfer1_valid", 4'(if_a.chg_valid), 4'b0000);
      chk("xfer1_mask",  if_a.chg_mask, 4'b0000);

      // Bit0 fall back to idle
      async_a = 4'b0000;
      step(7);
      chk("fall0_data",  data_a, 4'b0000);
      chk("fall0_fall",  fall_a, 4'b0001);
      chk("fall0_mask",  if_a.chg_mask, 4'b0001);
      chk("fall0_cdata", if_a.chg_data, 4'b0000);
      pulse_ready_a();
      chk("xfer2_valid", 4'(if_a.chg_valid), 4'b0000);

      // Glitch: bit1 high for only 3 cycles must vanish
      acc = 4'b0000;
      async_a = 4'b0010;
      for (int k = 0; k < 11; k++) begin
         if (k == 3) async_a = 4'b0000;
         step(1);
         acc = acc | data_a | rise_a | fall_a | {3'b000, if_a.chg_valid};
      end
      chk("glitch3_quiet", acc, 4'b0000);

      // Bit1 high for 4 cycles is accepted at edge 7, then drops again at edge 11
      async_a = 4'b0010;
      step(4);
      async_a = 4'b0000;
      step(2);
      chk("g4_e6_data", data_a, 4'b0000);
      step(1);
      chk("g4_e7_data",  data_a, 4'b0010);
      chk("g4_e7_rise",  rise_a, 4'b0010);
      chk("g4_e7_mask",  if_a.chg_mask, 4'b0010);
      step(4);
      chk("g4_e11_data",  data_a, 4'b0000);
      chk("g4_e11_fall",  fall_a, 4'b0010);
      chk("g4_e11_mask",  if_a.chg_mask, 4'b0010);
      chk("g4_e11_cdata", if_a.chg_data, 4'b0000);
      chk("g4_e11_ovr",   4'(if_a.chg_overrun), 4'b0001);
      pulse_ready_a();
      chk("xfer3_valid", 4'(if_a.chg_valid), 4'b0000);
      chk("xfer3_ovr",   4'(if_a.chg_overrun), 4'b0000);

      // Coalescing with chg_ready held low
      async_a = 4'b0001;
      step(7);
      chk("co_b0_mask", if_a.chg_mask, 4'b0001);
      async_a = 4'b0101;
      step(7);
      chk("co_b2_rise",  rise_a, 4'b0100);
      chk("co_b2_mask",  if_a.chg_mask, 4'b0101);
      chk("co_b2_cdata", if_a.chg_data, 4'b0101);
      chk("co_b2_ovr",   4'(if_a.chg_overrun), 4'b0000);
      async_a = 4'b0100;
      step(7);
      chk("co_f0_fall",  fall_a, 4'b0001);
      chk("co_f0_valid", 4'(if_a.chg_valid), 4'b0001);
      chk("co_f0_mask",  if_a.chg_mask, 4'b0101);
      chk("co_f0_cdata", if_a.chg_data, 4'b0100);
      chk("co_f0_ovr",   4'(if_a.chg_overrun), 4'b0001);
      pulse_ready_a();
      chk("co_x_valid", 4'(if_a.chg_valid), 4'b0000);
      chk("co_x_mask",  if_a.chg_mask, 4'b0000);
      chk("co_x_ovr",   4'(if_a.chg_overrun), 4'b0000);

      // Transfer on the same edge as an accepted bit3 change
      async_a = 4'b0110;
      step(7);
      chk("co3_pend_mask", if_a.chg_mask, 4'b0010);
      async_a = 4'b1110;
      step(6);
      pulse_ready_a();
      chk("co3_valid", 4'(if_a.chg_valid), 4'b0001);
      chk("co3_mask",  if_a.chg_mask, 4'b1000);
      chk("co3_ovr",   4'(if_a.chg_overrun), 4'b0000);
      chk("co3_cdata", if_a.chg_data, 4'b1110);
      chk("co3_rise",  rise_a, 4'b1000);
      pulse_ready_a();
      chk("co3_x_valid", 4'(if_a.chg_valid), 4'b0000);

      // Reset while the bit0 filter count is 2
      async_a = 4'b1111;
      step(5);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("mrst_data",  data_a, 4'b0000);
      chk("mrst_valid", 4'(if_a.chg_valid), 4'b0000);
      chk("mrst_rise",  rise_a, 4'b0000);
      chk("mrst_fall",  fall_a, 4'b0000);
      chk("mrst_mask",  if_a.chg_mask, 4'b0000);
      acc = 4'b0000;
      for (int k = 0; k < 6; k++) begin
         step(1);
         acc = acc | data_a | rise_a | fall_a;
      end
      chk("mrst_quiet_e1_e6", acc, 4'b0000);
      step(1);
      chk("mrst_e7_data",  data_a, 4'b1111);
      chk("mrst_e7_rise",  rise_a, 4'b1111);
      chk("mrst_e7_mask",  if_a.chg_mask, 4'b1111);

      // RESET_VALUE=1111 instance: silent while held, then bit2 fall after 7 edges
      chk("b_silent", b_seen, 4'b0000);
      async_b = 4'b1011;
      step(6);
      chk("b_e6_data", data_b, 4'b1111);
      chk("b_e6_fall", fall_b, 4'b0000);
      step(1);
      chk("b_e7_data",  data_b, 4'b1011);
      chk("b_e7_fall",  fall_b, 4'b0100);
      chk("b_e7_rise",  rise_b, 4'b0000);
      chk("b_e7_valid", 4'(if_b.chg_valid), 4'b0001);
      chk("b_e7_mask",  if_b.chg_mask, 4'b0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/arch_cdc_sync_filter.md
Name: arch_cdc_sync_filter

Overview:
Multi-channel synchroniser for asynchronous level inputs such as straps, PHY status and VBUS detect. Each channel passes through a parametrised flop chain and then a per-channel stability (deglitch) filter. The block produces per-channel rise/fall pulses and a coalescing change-event stream with a valid/ready handshake. It is the generalised successor of the fixed-depth CDC array and sits at the destination-domain boundary, upstream of USB control logic.

Parameters:
WIDTH, 2, number of independent channels (>=1).
SYNC_STAGES, 3, synchroniser flop depth (>=2).
FILTER_LEN, 4, consecutive cycles of a new level required before it is accepted (>=1; 1 = no filtering).
RESET_VALUE, {WIDTH{1'b0}}, reset/initial value of the synchroniser chain and of dst_data.

Ports:
dst_clk  in  1  destination clock; the only clock in the block.
dst_rst  in  1  synchronous, active-high reset.
async_in  in  WIDTH  asynchronous level inputs.
dst_data  out  WIDTH  filtered, synchronised levels.
dst_rise  out  WIDTH  1-cycle pulse per channel on an accepted 0->1 change.
dst_fall  out  WIDTH  1-cycle pulse per channel on an accepted 1->0 change.
chg_valid  out  1  change event pending.
chg_ready  in  1  consumer accepts the event.
chg_data  out  WIDTH  dst_data value at the most recent accepted change.
chg_mask  out  WIDTH  channels that changed since the last transfer.
chg_overrun  out  1  some channel in chg_mask changed more than once while the event was pending.

Behaviour:
- Clock and reset: one clock, dst_clk. Reset dst_rst is synchronous and active-high.
- Reset values: sync chain = RESET_VALUE; dst_data = RESET_VALUE; filter counters = 0; dst_rise, dst_fall, chg_valid, chg_mask, chg_overrun = 0; chg_data = RESET_VALUE. Reset asserted mid-operation aborts any in-progress filter count and discards any pending event. No pulses are produced in the cycle reset deasserts.
- Sync chain: SYNC_STAGES flops per channel; s = last stage. The first stage is the only flop that samples async_in. Chain flops carry ASYNC_REG/NOMERGE attributes.
- Filter, per channel i, with counter width clog2(FILTER_LEN) (minimum 1):
  - If s[i]==dst_data[i]: cnt<=0.
  - Else if cnt==FILTER_LEN-1: dst_data[i]<=s[i] and cnt<=0.
  - Else: cnt<=cnt+1.
  - A difference lasting fewer than FILTER_LEN consecutive cycles is discarded, and the counter restarts from 0.
- Latency: a level first sampled at edge 1 and held appears on dst_data at edge SYNC_STAGES+FILTER_LEN.
- Edge pulses: dst_rise[i]/dst_fall[i] are registered and high for exactly the one cycle in which dst_data[i] first shows the new value. Several channels may pulse in the same cycle.
- Change event, with chg = bits of dst_data that change at this edge:
  - Idle (chg_valid=0) and chg!=0: chg_valid<=1, chg_mask<=chg, chg_data<=new dst_data, chg_overrun<=0.
  - Pending and no transfer, with chg!=0: chg_mask<=chg_mask|chg and chg_data<=new dst_data. chg_overrun<=chg_overrun|(|(chg & chg_mask)).
  - Transfer (chg_valid&chg_ready) with chg==0: chg_valid<=0, chg_mask<=0, chg_overrun<=0.
  - Transfer with chg!=0 at the same edge: chg_valid stays 1, chg_mask<=chg, chg_data<=new dst_data, chg_overrun<=0. No change is lost.
- Coalescing: chg_data and chg_mask may update while chg_valid=1 and chg_ready=0. This is intentional and differs from AXI-Stream stability rules. chg_valid never drops without a transfer or reset.
- chg_ready is ignored while chg_valid=0.

Test Plan:
- WIDTH=4, SYNC_STAGES=3, FILTER_LEN=4, after reset: async_in=4'b0001 sampled at edge 1 and held -> dst_data=0001 at edge 7; dst_rise=0001 for that one cycle only; chg_valid=1, chg_mask=0001, chg_data=0001.
- Glitch: bit1 high for 3 cycles, then low -> dst_data, dst_rise, dst_fall and chg_valid all stay 0. Bit1 high for 4 cycles -> accepted at edge 7.
- Coalescing with chg_ready=0: bit0 rises, then bit2 rises -> chg_mask=0101, chg_data=0101, chg_overrun=0. Bit0 then falls -> chg_data=0100, chg_overrun=1. Pulse chg_ready for 1 cycle -> chg_valid=0, chg_mask=0, chg_overrun=0 the next cycle.
- Transfer coincident with an accepted bit3 change -> chg_valid stays 1, chg_mask=1000, chg_overrun=0.
- dst_rst asserted while the bit0 filter count=2 -> next cycle dst_data=RESET_VALUE, chg_valid=0, no pulses. After release, the full latency of 7 edges applies again.
- RESET_VALUE=4'b1111 with async_in=1111 held through reset -> no dst_rise, dst_fall or chg_valid ever. Dropping bit2 gives dst_fall=0100 after 7 edges.
